csr_to_avalon_mm_master: RTL and testbench
==========================================

// Module: csr_to_avalon_mm_master
// PURPOSE
//  Indirect-access bridge: csr_if slave register window that drives an Avalon-MM master port.
//  Software programs address/data/byteenable through 16-bit CSRs, then starts one 32-bit single-beat
//  access and polls status. Lets the register bank reach Avalon-MM slaves (e.g. fabric memories).
// PARAMETERS
//  CSR_ADDR_W  14   csr_if word-address width
//  CSR_DATA_W  16   csr_if data width; AMM_DATA_W == 2*CSR_DATA_W is required
//  BASE_ADDR   0    word address of register 0 of the window (8 words)
//  AMM_ADDR_W  32   Avalon byte-address width, <= 2*CSR_DATA_W
//  AMM_DATA_W  32   Avalon data width; AMM_BE_W = AMM_DATA_W/8
//  TIMEOUT_W   16   timeout counter width (used only with AMM_TIMEOUT_EN)
// PORTS
//  clk_i                  in   1           sole clock
//  rst_i                  in   1           asynchronous, active-high reset
//  csr_if                 csr_if.slave     addr/be/wr_data/wr_en in, rd_data out
//  amm_address_o          out  AMM_ADDR_W  Avalon byte address
//  amm_write_o            out  1           write request
//  amm_read_o             out  1           read request
//  amm_writedata_o        out  AMM_DATA_W  write data
//  amm_byteenable_o       out  AMM_BE_W    byte enables
//  amm_waitrequest_i      in   1           slave stall
//  amm_readdata_i         in   AMM_DATA_W  read data
//  amm_readdatavalid_i    in   1           read data strobe
// BEHAVIOUR
//  Register map (word offset from BASE_ADDR):
//   0 CTRL  W: [0] go (pulse), [1] rnw, [5:2] be, [15] clr_err. R: [0] busy, [1] rnw, [5:2] be, [8] done, [9] err
//   1 ADDR_LO  2 ADDR_HI  3 WDATA_LO  4 WDATA_HI  (RW)   5 RDATA_LO  6 RDATA_HI (RO)   7 TIMEOUT (RW)
//  csr write: wr_en && addr in window; honour csr be per byte. rd_data: combinational from addr, 0 outside window.
//  Writes to regs 0..4,7 ignored while busy (except clr_err, which is always honoured); go while busy ignored.
//  FSM: IDLE -> (go, rnw=0) WR | (go, rnw=1) RD_REQ.
//   WR: amm_write_o=1, outputs stable; on !waitrequest -> IDLE, done=1.
//   RD_REQ: amm_read_o=1; on !waitrequest -> RD_WAIT, or -> IDLE if readdatavalid same cycle.
//   RD_WAIT: on readdatavalid capture readdata into RDATA, done=1 -> IDLE.
//  go clears done, sets busy the next cycle (busy = state != IDLE); request asserted the cycle after go.
//  Min latency: write 1 cycle of amm_write_o; read completes the cycle readdatavalid is seen.
//  readdatavalid in IDLE or WR is discarded. ADDR_HI bits above AMM_ADDR_W ignored.
//  Reset: all amm outputs 0, state IDLE, all registers 0, TIMEOUT=all ones; async assert mid-access
//   drops read/write immediately; late readdatavalid after reset is discarded.
// CONFIGURATION
//  AMM_TIMEOUT_EN defined: counter loaded from TIMEOUT on go, decrements in WR/RD_REQ/RD_WAIT;
//   on reaching 0: drop request, err=1, done=0, -> IDLE. clr_err clears err. TIMEOUT=0 means no timeout.
//  Undefined: waits indefinitely; reg 7 reads 0, writes ignored; err reads 0.
// STRUCTURE
//  Package csr_amm_bridge_pkg: register offset localparams, CTRL/STATUS bit positions, state enum.
//  No sub-module; FSM, register file and timeout counter live in this module.
// TESTING
//  1 ADDR=0x0000_0100, WDATA=0xDEAD_BEEF, CTRL=0x003D, waitrequest 3 cycles -> amm_write_o high 4 cycles,
//    addr 0x100, data DEADBEEF, be 0xF; then CTRL reads 0x013C (done, idle).
//  2 ADDR=0x0000_0200, CTRL=0x003F; slave readdatavalid 5 cycles after accept with 0x1234_5678 ->
//    RDATA_LO=0x5678, RDATA_HI=0x1234, done=1, busy=0.
//  3 During test-2 read, write ADDR_LO=0xFFFF and CTRL=0x003D -> ignored; ADDR still 0x200, one access only.
//  4 AMM_TIMEOUT_EN, TIMEOUT=10, waitrequest stuck 1, read go -> amm_read_o drops after 10 cycles,
//    err=1, done=0; CTRL=0x8000 -> err=0.
//  5 rst_i asserted in RD_WAIT -> amm_read_o/write_o 0 same cycle, status 0; readdatavalid 3 cycles
//    after reset release leaves RDATA=0.
//  6 csr write ADDR_LO be=2'b01 data 0xABCD over 0x1111 -> ADDR_LO reads 0x11CD.

Source files
------------

// File: rtl/csr_amm_bridge_pkg.sv
// Shared definitions for the CSR-to-Avalon-MM indirect access bridge:
// register offsets inside the 8-word window, CTRL/STATUS bit positions,
// and the access state machine encoding.
package csr_amm_bridge_pkg;

  // Word offsets from the window base
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_ADDR_LO  = 3'd1;
  localparam logic [2:0] REG_ADDR_HI  = 3'd2;
  localparam logic [2:0] REG_WDATA_LO = 3'd3;
  localparam logic [2:0] REG_WDATA_HI = 3'd4;
  localparam logic [2:0] REG_RDATA_LO = 3'd5;
  localparam logic [2:0] REG_RDATA_HI = 3'd6;
  localparam logic [2:0] REG_TIMEOUT  = 3'd7;

  // CTRL write fields
  localparam int CTRL_GO      = 0;
  localparam int CTRL_RNW     = 1;
  localparam int CTRL_BE_LSB  = 2;
  localparam int CTRL_CLR_ERR = 15;

  // CTRL read (status) fields
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 8;
  localparam int STAT_ERR  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/csr_if.sv
// Simple register-bus interface: word address, per-byte enables, write
// strobe, and a combinational read-data return from the slave.
interface csr_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_data;

  modport slave  (input addr, be, wr_data, wr_en, output rd_data);
  modport master (output addr, be, wr_data, wr_en, input rd_data);
endinterface

// File: rtl/csr_to_avalon_mm_master.sv
// Indirect-access bridge: an 8-word CSR window that launches one 32-bit
// single-beat Avalon-MM read or write and reports busy/done/err.
// Optional macro AMM_TIMEOUT_EN adds a per-access timeout counter loaded
// from the TIMEOUT register; without it the bridge waits indefinitely.
//
// Avalon handshake: a request (read or write) is held with stable address,
// data and byteenable until a cycle where waitrequest is low; that cycle is
// the acceptance. Read data is taken only on a readdatavalid cycle while a
// read is outstanding (acceptance cycle included); any other readdatavalid
// is ignored.
module csr_to_avalon_mm_master
  import csr_amm_bridge_pkg::*;
#(
  parameter int CSR_ADDR_W = 14,
  parameter int CSR_DATA_W = 16,
  parameter int BASE_ADDR  = 0,
  parameter int AMM_ADDR_W = 32,
  parameter int AMM_DATA_W = 32,
  parameter int TIMEOUT_W  = 16,
  localparam int AMM_BE_W  = AMM_DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csr_if.slave                  csr_if,
  output logic [AMM_ADDR_W-1:0] amm_address_o,
  output logic                  amm_write_o,
  output logic                  amm_read_o,
  output logic [AMM_DATA_W-1:0] amm_writedata_o,
  output logic [AMM_BE_W-1:0]   amm_byteenable_o,
  input  logic                  amm_waitrequest_i,
  input  logic [AMM_DATA_W-1:0] amm_readdata_i,
  input  logic                  amm_readdatavalid_i,
  output state_t                dbg_state_o
);

  if (AMM_DATA_W != 2 * CSR_DATA_W) begin : g_bad_data_w
    $error("AMM_DATA_W must be twice CSR_DATA_W");
  end
  if (TIMEOUT_W < 1 || TIMEOUT_W > CSR_DATA_W) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be 1..CSR_DATA_W");
  end

  state_t                  r_state, w_next;
  logic                    r_rnw, r_done, r_err;
  logic [3:0]              r_be;
  logic [CSR_DATA_W-1:0]   r_addr_lo, r_addr_hi, r_wdata_lo, r_wdata_hi;
  logic [CSR_DATA_W-1:0]   r_rdata_lo, r_rdata_hi;
  logic [CSR_ADDR_W-1:0]   w_off;
  logic [2:0]              w_reg;
  logic                    w_in_win, w_wr, w_wr_cfg, w_busy, w_go, w_clr_err;
  logic                    w_wr_done, w_rd_done, w_timeout;
  logic [2*CSR_DATA_W-1:0] w_addr_full;
  logic [CSR_DATA_W-1:0]   w_rd_data;

  // Merge new data into a register honouring the per-byte enables
  function automatic logic [CSR_DATA_W-1:0] f_merge(
    input logic [CSR_DATA_W-1:0]   old_v,
    input logic [CSR_DATA_W-1:0]   new_v,
    input logic [CSR_DATA_W/8-1:0] be
  );
    logic [CSR_DATA_W-1:0] v;
    v = old_v;
    for (int b = 0; b < CSR_DATA_W / 8; b++) begin
      if (be[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return v;
  endfunction

  // Window decode: offset from base, in range when below 8 (wraps safely)
  assign w_off     = csr_if.addr - CSR_ADDR_W'(BASE_ADDR);
  assign w_in_win  = (w_off < CSR_ADDR_W'(8));
  assign w_reg     = w_off[2:0];
  assign w_wr      = csr_if.wr_en && w_in_win;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_wr_cfg  = w_wr && !w_busy;
  assign w_go      = w_wr_cfg && (w_reg == REG_CTRL) && csr_if.be[0] && csr_if.wr_data[CTRL_GO];
  assign w_clr_err = w_wr && (w_reg == REG_CTRL) && csr_if.be[1] && csr_if.wr_data[CTRL_CLR_ERR];

  // Completion events; they take priority over a coincident timeout
  assign w_wr_done = (r_state == ST_WR) && !amm_waitrequest_i;
  assign w_rd_done = ((r_state == ST_RD_REQ) && !amm_waitrequest_i && amm_readdatavalid_i) ||
                     ((r_state == ST_RD_WAIT) && amm_readdatavalid_i);

`ifdef AMM_TIMEOUT_EN
  logic [CSR_DATA_W-1:0] r_timeout;
  logic [TIMEOUT_W-1:0]  r_to_cnt;
  logic                  r_to_armed;

  // Expire on the last counted cycle so the request is held exactly TIMEOUT cycles
  assign w_timeout = w_busy && r_to_armed && (r_to_cnt == TIMEOUT_W'(1)) && !w_wr_done && !w_rd_done;

  // Timeout counter: loaded on go, counts down while an access is in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt   <= '0;
      r_to_armed <= 1'b0;
    end else if (w_go) begin
      r_to_cnt   <= TIMEOUT_W'(r_timeout);
      r_to_armed <= (r_timeout != '0);
    end else if (w_busy && r_to_cnt != '0) begin
      r_to_cnt   <= r_to_cnt - TIMEOUT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_go) w_next = csr_if.wr_data[CTRL_RNW] ? ST_RD_REQ : ST_WR;
      ST_WR:      if (!amm_waitrequest_i) w_next = ST_IDLE;
      ST_RD_REQ:  if (!amm_waitrequest_i) w_next = amm_readdatavalid_i ? ST_IDLE : ST_RD_WAIT;
      ST_RD_WAIT: if (amm_readdatavalid_i) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  // Request outputs decoded from state
  always_comb begin
    amm_write_o = 1'b0;
    amm_read_o  = 1'b0;
    case (r_state)
      ST_WR:     amm_write_o = 1'b1;
      ST_RD_REQ: amm_read_o  = 1'b1;
      default:   ;
    endcase
  end

  assign w_addr_full      = {r_addr_hi, r_addr_lo};
  assign amm_address_o    = w_addr_full[AMM_ADDR_W-1:0];
  assign amm_writedata_o  = {r_wdata_hi, r_wdata_lo};
  assign amm_byteenable_o = AMM_BE_W'(r_be);
  assign dbg_state_o      = r_state;

  // Register file: config writes when idle, status and read-data capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rnw      <= 1'b0;
      r_be       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr_lo  <= '0;
      r_addr_hi  <= '0;
      r_wdata_lo <= '0;
      r_wdata_hi <= '0;
      r_rdata_lo <= '0;
      r_rdata_hi <= '0;
`ifdef AMM_TIMEOUT_EN
      r_timeout  <= '1;
`endif
    end else begin
      if (w_wr_cfg) begin
        case (w_reg)
          REG_CTRL: if (csr_if.be[0]) begin
            r_rnw <= csr_if.wr_data[CTRL_RNW];
            r_be  <= csr_if.wr_data[CTRL_BE_LSB +: 4];
          end
          REG_ADDR_LO:  r_addr_lo  <= f_merge(r_addr_lo,  csr_if.wr_data, csr_if.be);
          REG_ADDR_HI:  r_addr_hi  <= f_merge(r_addr_hi,  csr_if.wr_data, csr_if.be);
          REG_WDATA_LO: r_wdata_lo <= f_merge(r_wdata_lo, csr_if.wr_data, csr_if.be);
          REG_WDATA_HI: r_wdata_hi <= f_merge(r_wdata_hi, csr_if.wr_data, csr_if.be);
`ifdef AMM_TIMEOUT_EN
          REG_TIMEOUT:  r_timeout  <= f_merge(r_timeout,  csr_if.wr_data, csr_if.be);
`endif
          default: ;
        endcase
      end
      if (w_go) r_done <= 1'b0;
      if (w_wr_done || w_rd_done) r_done <= 1'b1;
      if (w_rd_done) begin
        r_rdata_lo <= amm_readdata_i[CSR_DATA_W-1:0];
        r_rdata_hi <= amm_readdata_i[AMM_DATA_W-1:CSR_DATA_W];
      end
      if (w_clr_err) r_err <= 1'b0;
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_done <= 1'b0;
      end
    end
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    w_rd_data = '0;
    if (w_in_win) begin
      case (w_reg)
        REG_CTRL: begin
          w_rd_data[STAT_BUSY]         = w_busy;
          w_rd_data[CTRL_RNW]          = r_rnw;
          w_rd_data[CTRL_BE_LSB +: 4]  = r_be;
          w_rd_data[STAT_DONE]         = r_done;
          w_rd_data[STAT_ERR]          = r_err;
        end
        REG_ADDR_LO:  w_rd_data = r_addr_lo;
        REG_ADDR_HI:  w_rd_data = r_addr_hi;
        REG_WDATA_LO: w_rd_data = r_wdata_lo;
        REG_WDATA_HI: w_rd_data = r_wdata_hi;
        REG_RDATA_LO: w_rd_data = r_rdata_lo;
        REG_RDATA_HI: w_rd_data = r_rdata_hi;
`ifdef AMM_TIMEOUT_EN
        REG_TIMEOUT:  w_rd_data = r_timeout;
`endif
        default: ;
      endcase
    end
  end

  assign csr_if.rd_data = w_rd_data;

endmodule

// File: tb/tb_csr_to_avalon_mm_master.sv
// Bench for csr_to_avalon_mm_master: directed steps plus randomized accesses
// against a register-level model, with an Avalon slave model alongside.
module tb_csr_to_avalon_mm_master;
  import csr_amm_bridge_pkg::*;

  localparam int BASE = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_if #(.ADDR_W(14), .DATA_W(16)) u_csr ();

  logic [31:0] amm_address, amm_writedata, amm_readdata;
  logic        amm_write, amm_read, amm_waitrequest, amm_readdatavalid;
  logic [3:0]  amm_byteenable;
  state_t      dbg_state;

  csr_to_avalon_mm_master #(
    .CSR_ADDR_W(14), .CSR_DATA_W(16), .BASE_ADDR(BASE),
    .AMM_ADDR_W(32), .AMM_DATA_W(32), .TIMEOUT_W(16)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .csr_if              (u_csr),
    .amm_address_o       (amm_address),
    .amm_write_o         (amm_write),
    .amm_read_o          (amm_read),
    .amm_writedata_o     (amm_writedata),
    .amm_byteenable_o    (amm_byteenable),
    .amm_waitrequest_i   (amm_waitrequest),
    .amm_readdata_i      (amm_readdata),
    .amm_readdatavalid_i (amm_readdatavalid),
    .dbg_state_o         (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- Avalon slave model ----------------
  int          cfg_wait = 0, cfg_rdv_delay = 0;
  bit          cfg_stuck = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          kick_req = 0, kick_seen = 0, kick_delay = 3;
  int          wait_cnt = 0, pend = 0;
  int          wr_cyc = 0, rd_cyc = 0, n_acc = 0;
  logic [68:0] obs_mem [0:255];

  initial begin
    amm_waitrequest   = 1'b0;
    amm_readdatavalid = 1'b0;
    amm_readdata      = '0;
  end

  always @(negedge clk) begin
    amm_readdatavalid = 1'b0;
    if (kick_req != kick_seen) begin
      kick_seen = kick_req;
      pend      = kick_delay;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        amm_readdatavalid = 1'b1;
        amm_readdata      = cfg_rdata;
      end
    end
    if (amm_write) wr_cyc++;
    if (amm_read)  rd_cyc++;
    if (amm_write || amm_read) begin
      if (cfg_stuck || wait_cnt < cfg_wait) begin
        amm_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        amm_waitrequest = 1'b0;
        wait_cnt = 0;
        obs_mem[n_acc[7:0]] = {amm_read, amm_address, (amm_write ? amm_writedata : 32'h0), amm_byteenable};
        n_acc++;
        if (amm_read) begin
          if (cfg_rdv_delay == 0) begin
            amm_readdatavalid = 1'b1;
            amm_readdata      = cfg_rdata;
          end else begin
            pend = cfg_rdv_delay;
          end
        end
      end
    end else begin
      amm_waitrequest = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_reg [0:7];
  logic        m_rnw, m_done, m_err, m_busy;
  logic [3:0]  m_be;
  logic [68:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
`ifdef AMM_TIMEOUT_EN
    m_reg[7] = 16'hFFFF;
`endif
    m_rnw = 0; m_done = 0; m_err = 0; m_busy = 0; m_be = 4'h0;
    exp_q.delete();
  endtask

  function automatic logic [15:0] model_read(int off);
    case (off)
      0: return {6'b0, m_err, m_done, 2'b0, m_be, m_rnw, m_busy};
      1, 2, 3, 4, 5, 6: return m_reg[off];
`ifdef AMM_TIMEOUT_EN
      7: return m_reg[7];
`endif
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_write(int off, logic [15:0] d, logic [1:0] be);
    logic [15:0] mask;
    mask = {{8{be[1]}}, {8{be[0]}}};
    if (off == 0 && be[1] && d[15]) m_err = 1'b0;
    if (!m_busy) begin
      case (off)
        0: if (be[0]) begin m_rnw = d[1]; m_be = d[5:2]; end
        1, 2, 3, 4: m_reg[off] = (m_reg[off] & ~mask) | (d & mask);
`ifdef AMM_TIMEOUT_EN
        7: m_reg[7] = (m_reg[7] & ~mask) | (d & mask);
`endif
        default: ;
      endcase
    end
  endtask

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(int off, logic [15:0] d, logic [1:0] be);
    @(negedge clk);
    u_csr.addr    = 14'(BASE + off);
    u_csr.wr_data = d;
    u_csr.be      = be;
    u_csr.wr_en   = 1'b1;
    @(negedge clk);
    u_csr.wr_en   = 1'b0;
    model_write(off, d, be);
  endtask

  task automatic csr_read(int off, output logic [15:0] v);
    @(negedge clk);
    u_csr.addr  = 14'(BASE + off);
    u_csr.wr_en = 1'b0;
    #1 v = u_csr.rd_data;
  endtask

  task automatic check_reg(string tag, int off);
    logic [15:0] v;
    csr_read(off, v);
    check(tag, v, model_read(off));
  endtask

  task automatic wait_idle(string tag);
    logic [15:0] v;
    v = 16'h1;
    for (int i = 0; i < 300 && v[0]; i++) csr_read(0, v);
    check({tag, "_idle"}, v[0], 1'b0);
  endtask

  task automatic prog(logic [31:0] a, logic [31:0] wd);
    csr_write(1, a[15:0], 2'b11);
    csr_write(2, a[31:16], 2'b11);
    csr_write(3, wd[15:0], 2'b11);
    csr_write(4, wd[31:16], 2'b11);
  endtask

  bit          l_rnw;
  int          l_wait, snap_acc, snap_wr, snap_rd;
  logic [31:0] l_rdata;

  task automatic launch(bit rnw, logic [3:0] be, int wt, int dly, logic [31:0] rd);
    l_rnw = rnw; l_wait = wt; l_rdata = rd;
    cfg_wait = wt; cfg_rdv_delay = dly; cfg_rdata = rd;
    snap_acc = n_acc; snap_wr = wr_cyc; snap_rd = rd_cyc;
    exp_q.push_back({rnw, m_reg[2], m_reg[1], (rnw ? 32'h0 : {m_reg[4], m_reg[3]}), be});
    csr_write(0, {10'b0, be, rnw, 1'b1}, 2'b11);
    m_done = 1'b0;
    m_busy = 1'b1;
  endtask

  task automatic finish(string tag);
    logic [68:0] e;
    wait_idle(tag);
    m_busy = 1'b0;
    m_done = 1'b1;
    if (l_rnw) begin m_reg[5] = l_rdata[15:0]; m_reg[6] = l_rdata[31:16]; end
    e = exp_q.pop_front();
    check({tag, "_acc"}, n_acc - snap_acc, 1);
    if (n_acc != snap_acc) check({tag, "_txn"}, obs_mem[snap_acc[7:0]], e);
    check({tag, "_wrcyc"}, wr_cyc - snap_wr, l_rnw ? 0 : l_wait + 1);
    check({tag, "_rdcyc"}, rd_cyc - snap_rd, l_rnw ? l_wait + 1 : 0);
    check_reg({tag, "_ctrl"}, 0);
    check_reg({tag, "_rdlo"}, 5);
    check_reg({tag, "_rdhi"}, 6);
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_wr_drop"}, amm_write, 1'b0);
    check({tag, "_rd_drop"}, amm_read, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed / random sequence ----------------
  initial begin
    logic [15:0] v;
    int snap;
    rst = 1'b1;
    u_csr.addr = '0; u_csr.be = '0; u_csr.wr_data = '0; u_csr.wr_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_write", amm_write, 1'b0);
    check("rst_read", amm_read, 1'b0);
    check("rst_addr", amm_address, 32'h0);
    check("rst_wdata", amm_writedata, 32'h0);
    check("rst_be", amm_byteenable, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) check_reg($sformatf("rst_reg%0d", i), i);

    // Byte-enable merge and window edges
    csr_write(1, 16'h1111, 2'b11);
    csr_write(1, 16'hABCD, 2'b01);
    check_reg("be_lo_merge", 1);
    csr_read(1, v);
    check("be_lo_11cd", v, 16'h11CD);
    csr_write(1, 16'h5A00, 2'b10);
    check_reg("be_hi_merge", 1);
    csr_write(8, 16'h7777, 2'b11);
    check_reg("outside_wr_ignored", 1);
    csr_read(-1, v);
    check("outside_below", v, 16'h0);
    csr_read(8, v);
    check("outside_above", v, 16'h0);
    csr_write(7, 16'h000A, 2'b11);
    check_reg("timeout_reg", 7);

    // Write with 3 waitrequest cycles
    prog(32'h0000_0100, 32'hDEAD_BEEF);
    launch(1'b0, 4'hF, 3, 0, 32'h0);
    finish("t1");
    csr_read(0, v);
    check("t1_ctrl_013c", v, 16'h013C);

    // Read with late readdatavalid, config writes while busy are ignored
    prog(32'h0000_0200, 32'hDEAD_BEEF);
    launch(1'b1, 4'hF, 1, 5, 32'h1234_5678);
    csr_write(1, 16'hFFFF, 2'b11);
    csr_write(0, 16'h003D, 2'b11);
    finish("t2");
    csr_read(5, v); check("t2_rdlo", v, 16'h5678);
    csr_read(6, v); check("t2_rdhi", v, 16'h1234);
    csr_read(1, v); check("t3_addr_kept", v, 16'h0200);
    repeat (4) @(negedge clk);
    check("t3_single_access", n_acc - snap_acc, 1);

    // readdatavalid while idle and during a write is discarded
    cfg_rdata = 32'hCAFE_F00D; kick_delay = 2; kick_req++;
    repeat (5) @(negedge clk);
    check_reg("idle_rdv_lo", 5);
    check_reg("idle_rdv_hi", 6);
    prog(32'h0000_0300, 32'h0BAD_F00D);
    launch(1'b0, 4'h3, 3, 0, 32'h5555_AAAA);
    kick_delay = 1; kick_req++;
    finish("wr_rdv");

    // Randomized accesses
    for (int n = 0; n < 16; n++) begin
      prog($urandom, $urandom);
      launch(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
      finish($sformatf("rnd%0d", n));
    end

`ifdef AMM_TIMEOUT_EN
    // Stuck waitrequest times out after TIMEOUT cycles
    csr_write(7, 16'd10, 2'b11);
    cfg_stuck = 1'b1;
    snap = n_acc; snap_rd = rd_cyc;
    csr_write(0, 16'h003F, 2'b11);
    m_busy = 1'b1; m_done = 1'b0;
    wait_idle("to");
    m_busy = 1'b0; m_err = 1'b1; m_done = 1'b0;
    check("to_rdcyc", rd_cyc - snap_rd, 10);
    check("to_no_accept", n_acc - snap, 0);
    check_reg("to_ctrl_err", 0);
    csr_write(0, 16'h8000, 2'b10);
    check_reg("to_clr_err", 0);
    cfg_stuck = 1'b0;
`endif

    // Reset while a read request is stalled
    prog(32'h0000_0400, 32'h0);
    cfg_stuck = 1'b1;
    csr_write(0, 16'h003F, 2'b11);
    repeat (2) @(negedge clk);
    check("rst_req_rd_before", amm_read, 1'b1);
    async_reset("rst_req");
    cfg_stuck = 1'b0;
    check_reg("rst_req_ctrl", 0);

    // Reset while waiting for read data; late readdatavalid is dropped
    prog(32'h0000_0500, 32'h0);
    snap = n_acc;
    cfg_wait = 0; cfg_rdv_delay = 100; cfg_rdata = 32'h8765_4321;
    csr_write(0, 16'h003F, 2'b11);
    for (int i = 0; i < 50 && n_acc == snap; i++) @(negedge clk);
    check("rdwait_accept", n_acc - snap, 1);
    repeat (2) @(negedge clk);
    async_reset("rst_wait");
    kick_delay = 3; kick_req++;
    repeat (6) @(negedge clk);
    check_reg("rst_wait_rdlo", 5);
    check_reg("rst_wait_rdhi", 6);
    check_reg("rst_wait_ctrl", 0);
    check_reg("rst_wait_addr", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
